// File: rtl/morph_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : morph_frame_ctrl
// Purpose  : Frame sequencer for the streaming binary erosion core: counts,
//            flushes line-buffer latency, bypasses and reports frame status.
//            Optional MORPH_BORDER_ZERO_EN zeroes the output image border.
// Revision : 1.0
// ============================================================================
module morph_frame_ctrl #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int FLUSH_MAX = 2*WIDTH+2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic cfg_bypass,
    input  logic src_write,
    input  logic src_pixel,
    output logic ero_write,
    output logic ero_pixel,
    input  logic ero_read,
    input  logic ero_out,
    output logic dst_write,
    output logic dst_pixel,
    output logic busy,
    output logic frame_done,
    output logic err_drop,
    output logic err_timeout
);

    localparam int c_COL_W = $clog2(WIDTH);
    localparam int c_ROW_W = $clog2(HEIGHT);
    localparam int c_CNT_W = $clog2(WIDTH*HEIGHT+1);
    localparam int c_DRN_W = $clog2(FLUSH_MAX+1);

    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(WIDTH-1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(HEIGHT-1);
    localparam logic [c_CNT_W-1:0] c_TOTAL     = c_CNT_W'(WIDTH*HEIGHT);
    localparam logic [c_DRN_W-1:0] c_FLUSH_MAX = c_DRN_W'(FLUSH_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_bypass;
    logic [c_COL_W-1:0] r_in_col;
    logic [c_ROW_W-1:0] r_in_row;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic [c_DRN_W-1:0] r_drain_cnt;
    logic               r_dst_write;
    logic               r_dst_pixel;
    logic               r_err_drop;
    logic               r_err_timeout;

    logic               w_run;
    logic               w_drain;
    logic               w_out_src;
    logic               w_out_fire;
    logic               w_out_pix;
    logic               w_border;
    logic [c_CNT_W-1:0] w_out_cnt_next;
    logic [c_DRN_W-1:0] w_drain_next;

    assign w_run   = (r_state == ST_RUN);
    assign w_drain = (r_state == ST_DRAIN);

    // Output source: raw input stream in bypass, core results otherwise
    assign w_out_src      = r_bypass ? (w_run && src_write)
                                     : ((w_run || w_drain) && ero_read);
    assign w_out_fire     = w_out_src && (r_out_cnt != c_TOTAL);
    assign w_out_pix      = r_bypass ? src_pixel : ero_out;
    assign w_out_cnt_next = r_out_cnt + c_CNT_W'(w_out_fire);
    assign w_drain_next   = r_drain_cnt + c_DRN_W'(1);

`ifdef MORPH_BORDER_ZERO_EN
    logic [c_COL_W-1:0] r_out_col;
    logic [c_ROW_W-1:0] r_out_row;

    assign w_border = (r_out_col == '0) || (r_out_col == c_COL_LAST) ||
                      (r_out_row == '0) || (r_out_row == c_ROW_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_col <= '0;
            r_out_row <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_out_col <= '0;
            r_out_row <= '0;
        end else if (w_out_fire) begin
            if (r_out_col == c_COL_LAST) begin
                r_out_col <= '0;
                r_out_row <= (r_out_row == c_ROW_LAST) ? '0 : r_out_row + c_ROW_W'(1);
            end else begin
                r_out_col <= r_out_col + c_COL_W'(1);
            end
        end
    end
`else
    assign w_border = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bypass      <= 1'b0;
            r_in_col      <= '0;
            r_in_row      <= '0;
            r_out_cnt     <= '0;
            r_drain_cnt   <= '0;
            r_dst_write   <= 1'b0;
            r_dst_pixel   <= 1'b0;
            r_err_drop    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_dst_write <= w_out_fire;
            r_dst_pixel <= w_out_fire && w_out_pix && !w_border;
            r_out_cnt   <= w_out_cnt_next;
            if (src_write && !w_run)
                r_err_drop <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state       <= ST_RUN;
                        r_bypass      <= cfg_bypass;
                        r_in_col      <= '0;
                        r_in_row      <= '0;
                        r_out_cnt     <= '0;
                        r_drain_cnt   <= '0;
                        // A pixel coincident with start is still a drop
                        r_err_drop    <= src_write;
                        r_err_timeout <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (src_write) begin
                        if (r_in_col == c_COL_LAST) begin
                            r_in_col <= '0;
                            if (r_in_row == c_ROW_LAST) begin
                                r_in_row    <= '0;
                                r_drain_cnt <= '0;
                                r_state     <= ST_DRAIN;
                            end else begin
                                r_in_row <= r_in_row + c_ROW_W'(1);
                            end
                        end else begin
                            r_in_col <= r_in_col + c_COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= w_drain_next;
                    // Completion takes precedence over a coincident timeout
                    if (r_bypass || (w_out_cnt_next == c_TOTAL)) begin
                        r_state <= ST_DONE;
                    end else if (w_drain_next == c_FLUSH_MAX) begin
                        r_state       <= ST_DONE;
                        r_err_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Drain feeds zeros to push the last lines out of the core's buffers
    assign ero_write   = !r_bypass && ((w_run && src_write) ||
                                       (w_drain && (r_out_cnt != c_TOTAL)));
    assign ero_pixel   = !r_bypass && w_run && src_pixel;
    assign dst_write   = r_dst_write;
    assign dst_pixel   = r_dst_pixel;
    assign busy        = w_run || w_drain;
    assign frame_done  = (r_state == ST_DONE);
    assign err_drop    = r_err_drop;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_morph_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_morph_frame_ctrl
// Purpose  : Self-checking bench for morph_frame_ctrl on an 8x8 frame with a
//            latency-configurable erosion core stub.
// Revision : 1.0
// ============================================================================
module tb_morph_frame_ctrl;

    localparam int c_W   = 8;
    localparam int c_H   = 8;
    localparam int c_PIX = c_W * c_H;

    logic clock;
    logic reset_n;
    logic start;
    logic cfg_bypass;
    logic src_write;
    logic src_pixel;
    logic ero_write;
    logic ero_pixel;
    logic ero_read;
    logic ero_out;
    logic dst_write;
    logic dst_pixel;
    logic busy;
    logic frame_done;
    logic err_drop;
    logic err_timeout;

    morph_frame_ctrl #(
        .WIDTH  (c_W),
        .HEIGHT (c_H)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .cfg_bypass  (cfg_bypass),
        .src_write   (src_write),
        .src_pixel   (src_pixel),
        .ero_write   (ero_write),
        .ero_pixel   (ero_pixel),
        .ero_read    (ero_read),
        .ero_out     (ero_out),
        .dst_write   (dst_write),
        .dst_pixel   (dst_pixel),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_drop    (err_drop),
        .err_timeout (err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Erosion core stub: echoes written pixels after a lag of stub_lag writes
    int   stub_lag;
    bit   stub_never;
    bit   stub_clr;
    int   stub_cnt;
    int   stub_idx;
    logic stub_mem [0:127];

    always_ff @(posedge clock) begin
        if (!reset_n || stub_clr) begin
            stub_cnt <= 0;
        end else if (ero_write) begin
            stub_mem[stub_cnt[6:0]] <= ero_pixel;
            stub_cnt <= stub_cnt + 1;
        end
    end

    always_comb begin
        stub_idx = 0;
        if (stub_cnt >= stub_lag)
            stub_idx = stub_cnt - stub_lag;
        ero_read = ero_write && !stub_never && (stub_cnt >= stub_lag);
        ero_out  = (stub_lag == 0) ? ero_pixel : stub_mem[stub_idx[6:0]];
    end

    typedef struct {
        bit bypass;
        int pat;
        int lag;
        bit never;
        bit pre_drop;
        bit coinc;
        bit start_mid;
        int exp_dst;
        int exp_ero;
        int exp_gap;
        bit exp_to;
        bit exp_drop;
    } vec_t;

    vec_t vecs [7];
    bit   sb [$];
    int   n_chk;
    int   n_err;
    int   cyc;
    int   dst_cnt;
    int   ero_cnt;
    int   fd_cnt;
    int   fd_cyc;
    int   last_dst;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Combinational outputs sampled 1ns after inputs change, registered ones at negedge
    task automatic step();
        bit e;
        #1;
        if (ero_write === 1'b1)
            ero_cnt++;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (dst_write === 1'b1) begin
            dst_cnt++;
            last_dst = cyc;
            if (sb.size() == 0) begin
                check("dst_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("dst_pixel", int'(dst_pixel), int'(e));
            end
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    endtask

    function automatic bit gen_pix(input int pat, input int k);
        if (pat == 0) return 1'b1;
        if (pat == 1) return k[0];
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit exp_pix(input bit p, input int k);
`ifdef MORPH_BORDER_ZERO_EN
        int r;
        int c;
        r = k / c_W;
        c = k % c_W;
        if (r == 0 || r == c_H-1 || c == 0 || c == c_W-1)
            return 1'b0;
`endif
        return p;
    endfunction

    task automatic run_frame(input int idx, input vec_t v);
        bit p;
        int budget;
        stub_lag   = v.lag;
        stub_never = v.never;
        stub_clr   = 1'b1;
        step();
        stub_clr   = 1'b0;
        if (v.pre_drop) begin
            src_write = 1'b1;
            src_pixel = 1'b1;
            step();
            src_write = 1'b0;
            check("err_drop_idle", int'(err_drop), 1);
        end
        dst_cnt = 0;
        ero_cnt = 0;
        fd_cnt  = 0;
        fd_cyc  = 0;
        last_dst = 0;
        start      = 1'b1;
        cfg_bypass = v.bypass;
        src_write  = v.coinc;
        src_pixel  = 1'b1;
        step();
        start      = 1'b0;
        cfg_bypass = 1'b0;
        check("busy_run", int'(busy), 1);
        for (int k = 0; k < c_PIX; k++) begin
            p = gen_pix(v.pat, k);
            src_write = 1'b1;
            src_pixel = p;
            start     = v.start_mid && (k == 30);
            sb.push_back(exp_pix(p, k));
            step();
        end
        src_write = 1'b0;
        src_pixel = 1'b0;
        start     = 1'b0;
        budget = 0;
        while (fd_cnt == 0 && budget < 200) begin
            step();
            budget++;
        end
        if (fd_cnt == 0)
            check("frame_done_seen", 0, 1);
        step();
        $display("frame %0d: dst=%0d ero=%0d gap=%0d", idx, dst_cnt, ero_cnt, fd_cyc - last_dst);
        check("busy_idle", int'(busy), 0);
        check("frame_done_pulses", fd_cnt, 1);
        check("dst_count", dst_cnt, v.exp_dst);
        check("ero_count", ero_cnt, v.exp_ero);
        check("err_timeout", int'(err_timeout), int'(v.exp_to));
        check("err_drop", int'(err_drop), int'(v.exp_drop));
        if (v.exp_gap >= 0)
            check("frame_done_gap", fd_cyc - last_dst, v.exp_gap);
        if (v.exp_dst == c_PIX)
            check("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        stub_lag   = 0;
        stub_never = 1'b0;
        stub_clr   = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        cfg_bypass = 1'b0;
        src_write  = 1'b0;
        src_pixel  = 1'b0;

        //             byp pat lag nev pre coi mid dst ero gap to drop
        vecs[0] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64, 64,  1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 64, 73,  0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64,  0,  1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2, 5, 1'b0, 1'b1, 1'b0, 1'b1, 64, 69,  0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 82, -1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64,  0,  1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64, 64,  1, 1'b0, 1'b0};

        step();
        step();
        check("rst_dst_write",   int'(dst_write),   0);
        check("rst_dst_pixel",   int'(dst_pixel),   0);
        check("rst_busy",        int'(busy),        0);
        check("rst_frame_done",  int'(frame_done),  0);
        check("rst_err_drop",    int'(err_drop),    0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check("rst_ero_write",   int'(ero_write),   0);
        check("rst_ero_pixel",   int'(ero_pixel),   0);
        reset_n = 1'b1;
        step();
        check("idle_busy", int'(busy), 0);

        // Reset in the middle of a frame: back to idle, no completion pulse
        fd_cnt = 0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            src_write = 1'b1;
            src_pixel = 1'b1;
            sb.push_back(exp_pix(1'b1, k));
            step();
        end
        src_write = 1'b0;
        reset_n   = 1'b0;
        step();
        check("midrst_busy",       int'(busy),       0);
        check("midrst_dst_write",  int'(dst_write),  0);
        check("midrst_dst_pixel",  int'(dst_pixel),  0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_ero_write",  int'(ero_write),  0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++)
            step();
        check("midrst_no_done", fd_cnt, 0);
        sb.delete();

        for (int i = 0; i < 7; i++)
            run_frame(i, vecs[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
